ir_nec_transmit: RTL

- NEC-protocol infrared transmitter; the sending counterpart of the IR_RECEIVE decoder already used on the board.
- Serialises a 32-bit word in the same layout the receiver produces: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd. The receiver's keycode field is [23:16].
- Drives an IR LED output with an optional 38 kHz carrier. Used for loopback testing of the IR/SRAM command path and for board-to-board remote control.

---
 rtl/ir_pkg.sv | 30 +++
 rtl/ir_carrier_gen.sv | 42 ++++
 rtl/ir_nec_transmit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR transmitter and IR_RECEIVE users:
// FSM states, NEC unit counts and 32-bit frame field positions.
package ir_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK,
      GAP,
      DONE
   } ir_state_e;

   localparam int LEAD_MARK_U  = 16;
   localparam int LEAD_SPACE_U = 8;
   localparam int RPT_SPACE_U  = 4;
   localparam int ONE_SPACE_U  = 3;

   // Frame layout: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd
   localparam int ADDR_LSB = 0;
   localparam int CMD_LSB  = 16;

   // Counter width for a 0..n-1 counter, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier divider: toggles every CARRIER_HALF cycles while enabled, restarts
// high on i_restart and sits low when disabled.
module ir_carrier_gen
   import ir_pkg::*;
#(
   parameter int CARRIER_HALF = 658
) (
   input  logic Clk,
   input  logic rst_n,
   input  logic i_restart,
   input  logic i_en,
   output logic o_carrier
);

   localparam int CW = cnt_w(CARRIER_HALF);

   logic [CW-1:0] r_cnt;
   logic          r_car;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_car <= 1'b0;
      end else if (i_restart) begin
         r_cnt <= '0;
         r_car <= 1'b1;
      end else if (i_en) begin
         if (r_cnt == CW'(CARRIER_HALF - 1)) begin
            r_cnt <= '0;
            r_car <= ~r_car;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
         r_car <= 1'b0;
      end
   end

   assign o_carrier = r_car;

endmodule

// File: rtl/ir_nec_transmit.sv
// NEC infrared transmitter: serialises a 32-bit frame (LSB first) or a repeat
// code into a mark/space envelope, optionally gated by a 38 kHz carrier.
module ir_nec_transmit
   import ir_pkg::*;
#(
   parameter int UNIT_CYCLES  = 28125,
   parameter int CARRIER_HALF = 658,
   parameter int MODULATE     = 1,
   parameter int GAP_UNITS    = 16
) (
   input  logic        Clk,
   input  logic        rst_n,
   input  logic        tx_start,
   input  logic        tx_repeat,
   input  logic [31:0] tx_data,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        tx_env,
   output logic        IRDA_TXD
);

   localparam int UC_W  = cnt_w(UNIT_CYCLES);
   localparam int MAX_U = (GAP_UNITS > LEAD_MARK_U) ? GAP_UNITS : LEAD_MARK_U;
   localparam int UL_W  = $clog2(MAX_U + 1);

   ir_state_e   r_state, w_nxt_state;
   logic [UC_W-1:0] r_unit_cnt, w_nxt_ucnt;
   logic [UL_W-1:0] r_units_left, w_nxt_units;
   logic [4:0]  r_bit_idx, w_nxt_bit;
   logic [31:0] r_data, w_nxt_data;
   logic        r_rpt, w_nxt_rpt;
   logic        r_env, r_busy, r_done;
   logic        w_timed, w_unit_end, w_seg_end;
   logic        w_nxt_env, w_nxt_busy, w_car;

   assign w_timed    = (r_state != IDLE) && (r_state != DONE);
   assign w_unit_end = w_timed && (r_unit_cnt == UC_W'(UNIT_CYCLES - 1));
   assign w_seg_end  = w_unit_end && (r_units_left == UL_W'(1));

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ucnt  = '0;
      w_nxt_units = r_units_left;
      w_nxt_bit   = r_bit_idx;
      w_nxt_data  = r_data;
      w_nxt_rpt   = r_rpt;
      if (w_timed && !w_unit_end)
         w_nxt_ucnt = r_unit_cnt + 1'b1;
      if (w_unit_end && !w_seg_end)
         w_nxt_units = r_units_left - 1'b1;
      case (r_state)
         IDLE: begin
            // start wins over repeat when both are requested
            if (tx_start) begin
               w_nxt_state = LEAD_MARK;
               w_nxt_units = UL_W'(LEAD_MARK_U);
               w_nxt_data  = tx_data;
               w_nxt_rpt   = 1'b0;
               w_nxt_bit   = '0;
            end else if (tx_repeat) begin
               w_nxt_state = LEAD_MARK;
               w_nxt_units = UL_W'(LEAD_MARK_U);
               w_nxt_rpt   = 1'b1;
               w_nxt_bit   = '0;
            end
         end
         LEAD_MARK: if (w_seg_end) begin
            w_nxt_state = LEAD_SPACE;
            w_nxt_units = r_rpt ? UL_W'(RPT_SPACE_U) : UL_W'(LEAD_SPACE_U);
         end
         LEAD_SPACE: if (w_seg_end) begin
            w_nxt_state = r_rpt ? STOP_MARK : BIT_MARK;
            w_nxt_units = UL_W'(1);
         end
         BIT_MARK: if (w_seg_end) begin
            w_nxt_state = BIT_SPACE;
            w_nxt_units = r_data[r_bit_idx] ? UL_W'(ONE_SPACE_U) : UL_W'(1);
         end
         BIT_SPACE: if (w_seg_end) begin
            w_nxt_bit   = r_bit_idx + 1'b1;
            w_nxt_state = (r_bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
            w_nxt_units = UL_W'(1);
         end
         STOP_MARK: if (w_seg_end) begin
            if (GAP_UNITS == 0) begin
               w_nxt_state = DONE;
            end else begin
               w_nxt_state = GAP;
               w_nxt_units = UL_W'(GAP_UNITS);
            end
         end
         GAP: if (w_seg_end) w_nxt_state = DONE;
         DONE: w_nxt_state = IDLE;
         default: w_nxt_state = IDLE;
      endcase
   end

   assign w_nxt_env  = (w_nxt_state == LEAD_MARK) || (w_nxt_state == BIT_MARK) ||
                       (w_nxt_state == STOP_MARK);
   assign w_nxt_busy = (w_nxt_state != IDLE) && (w_nxt_state != DONE);

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_unit_cnt   <= '0;
         r_units_left <= '0;
         r_bit_idx    <= '0;
         r_data       <= '0;
         r_rpt        <= 1'b0;
         r_env        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_unit_cnt   <= w_nxt_ucnt;
         r_units_left <= w_nxt_units;
         r_bit_idx    <= w_nxt_bit;
         r_data       <= w_nxt_data;
         r_rpt        <= w_nxt_rpt;
         r_env        <= w_nxt_env;
         r_busy       <= w_nxt_busy;
         r_done       <= (w_nxt_state == DONE);
      end
   end

   // Marks never abut, so a rising envelope marks the first cycle of each mark
   ir_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_car (
      .Clk       (Clk),
      .rst_n     (rst_n),
      .i_restart (w_nxt_env & ~r_env),
      .i_en      (w_nxt_env),
      .o_carrier (w_car)
   );

   assign tx_busy  = r_busy;
   assign tx_done  = r_done;
   assign tx_env   = r_env;
   assign IRDA_TXD = (MODULATE != 0) ? w_car : r_env;

endmodule
